divm_sched: RTL and testbench
=============================

// Module: divm_sched
// PURPOSE
//   Run-time controller for the divide-by-M clock generator. It produces clk_out at clk_in/div_q.
//   Software or a parent FSM may change the divisor M through a valid/ready port, and start or stop
//   the output with en. Divisor changes and stops take effect only at an output-period boundary,
//   so clk_out never carries a runt pulse. Sits between the config/control logic and the clock-enable consumers.
// PARAMETERS
//   W           8   width of the divisor and the period counter
//   DIV_DEFAULT 4   divisor loaded at reset; must be >= 2 and < 2**W
// PORTS
//   clk_in      in   1  system clock; all logic on its rising edge
//   reset_L     in   1  asynchronous, active-low reset
//   en          in   1  run request: 1 = generate clk_out, 0 = stop at the next period end
//   cfg_valid   in   1  new divisor offered on cfg_div
//   cfg_div     in   W  requested divisor M
//   cfg_ready   out  1  controller can accept a divisor this cycle
//   cfg_err     out  1  one-cycle pulse: accepted cfg_div was < 2 and was discarded
//   clk_out     out  1  divided clock, registered
//   tick        out  1  one-cycle pulse in the last clk_in cycle of each output period
//   div_cur     out  W  divisor currently in effect (div_q)
//   running     out  1  1 while in state RUN or STOPPING
// BEHAVIOUR
//   Reset (async, reset_L=0)
//     - state=IDLE, cnt=0, div_q=DIV_DEFAULT, pend_v=0.
//     - clk_out=0, tick=0, cfg_err=0, cfg_ready=1, running=0, div_cur=DIV_DEFAULT.
//   Period counter
//     - cnt counts 0..div_q-1 and wraps to 0 (modulo div_q, W bits, no overflow possible).
//     - hi = (div_q+1)>>1.
//     - While RUN or STOPPING, in the cycle where cnt=k: clk_out = (k < hi). Odd M gives the extra high cycle.
//     - tick = 1 exactly when cnt = div_q-1 in RUN or STOPPING.
//   States
//     - IDLE: cnt held at 0, clk_out=0. en=1 -> RUN; the first RUN cycle has cnt=0 and clk_out=1.
//     - RUN: counts. en=0 -> STOPPING; the count continues uninterrupted.
//     - STOPPING: counts.
//       - en=1 -> RUN, with no phase disturbance.
//       - At cnt=div_q-1 with en=0 -> IDLE. The period always completes; clk_out is 0 in the following cycle.
//   Config handshake
//     - cfg_ready = !pend_v.
//     - Transfer occurs when cfg_valid & cfg_ready at a rising edge.
//     - Accepted cfg_div < 2: discarded, cfg_err pulses the next cycle, pend_v stays 0.
//     - Otherwise cfg_div is latched into pend and pend_v <= 1.
//   Divisor update
//     - pend_v=1 in IDLE: div_q <= pend and pend_v <= 0 at the next edge.
//     - pend_v=1 in RUN/STOPPING: applied at the edge where cnt = div_q-1, so the next period starts
//       at cnt=0 with the new M. pend_v clears at that edge; cfg_ready returns 1.
//   Simultaneous events
//     - Transfer at the same edge as a period end: the new value goes to pend and is applied at the
//       following boundary, not the current one.
//     - Stop and update at the same boundary: both take effect, giving IDLE with the new div_q.
//     - div_q never changes mid-period.
//   Reset mid-operation
//     - Immediate return to reset values. clk_out drops asynchronously; a pending divisor is lost.
// TESTING
//   1. Reset, en=1, M=4 -> clk_out 1,1,0,0 repeating; tick on every 4th cycle; running=1.
//   2. Running M=4, offer cfg_div=6 at cnt=1 -> cfg_ready falls; current period ends with 4 cycles;
//      next period is 3 high + 3 low; div_cur=6 from the boundary.
//   3. Running M=4, offer cfg_div=3 on the boundary edge (cnt=3) -> one more M=4 period, then pattern 1,1,0.
//   4. cfg_div=1 and cfg_div=0 -> cfg_err pulses once each; div_cur unchanged; clk_out unaffected.
//   5. M=5, drop en at cnt=1 -> output completes 1,1,1,0,0 then stays 0, running=0.
//      A separate run dropping and re-raising en within the period -> no gap, no phase change.
//   6. Assert reset_L=0 mid-period with pend_v=1 -> all outputs at reset values immediately;
//      after release with en=1, M=DIV_DEFAULT is used.

Source files
------------

// File: rtl/divm_sched_if.sv
// Divisor configuration port for divm_sched.
//   cfg_valid  master -> slave  new divisor offered on cfg_div
//   cfg_div    master -> slave  requested divisor M
//   cfg_ready  slave -> master  controller can take a divisor this cycle
//   cfg_err    slave -> master  one-cycle pulse: accepted divisor < 2 was discarded
interface divm_sched_if #(
  parameter int W = 8
);
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/divm_sched.sv
// Run-time controller for the divide-by-M clock generator.
// clk_out = clk_in / div_cur. Divisor changes and stops only land on an
// output-period boundary, so clk_out never carries a runt pulse.
// Ports:
//   clk_in   system clock (rising edge)
//   reset_L  asynchronous active-low reset
//   en       run request; 0 stops at the end of the current period
//   cfg      divisor handshake (divm_sched_if.slave)
//   clk_out  divided clock, registered
//   tick     pulse in the last clk_in cycle of each output period
//   div_cur  divisor currently in effect
//   running  1 while RUN or STOPPING
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | output parked low, counter held at 0, pending divisor applied
// RUN      | counting periods, en=1
// STOPPING | en dropped; finishing the current period, then IDLE
module divm_sched #(
  parameter int W           = 8,
  parameter int DIV_DEFAULT = 4
) (
  input  logic         clk_in,
  input  logic         reset_L,
  input  logic         en,
  divm_sched_if.slave  cfg,
  output logic         clk_out,
  output logic         tick,
  output logic [W-1:0] div_cur,
  output logic         running
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] TWO     = W'(2);
  localparam logic [W-1:0] DIV_RST = W'(DIV_DEFAULT);

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0] r_div_q, w_div_nxt;
  logic [W-1:0] r_pend, w_pend_nxt;
  logic         r_pend_v, w_pend_v_nxt;
  logic         r_clk_out, w_clk_nxt;
  logic         r_tick, w_tick_nxt;
  logic         r_cfg_err, w_cfg_err_nxt;
  logic         w_last, w_xfer, w_active_nxt;
  logic [W:0]   w_hi_nxt;

  always_ff @(posedge clk_in or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_div_q   <= DIV_RST;
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div_q   <= w_div_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_v  <= w_pend_v_nxt;
      r_clk_out <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_nxt     = r_div_q;
    w_pend_nxt    = r_pend;
    w_pend_v_nxt  = r_pend_v;
    w_cfg_err_nxt = 1'b0;

    w_last = (r_state != ST_IDLE) && (r_cnt == r_div_q - ONE);
    // Transfer only when nothing is pending, so a transfer and an apply never
    // collide; a transfer on a boundary edge waits for the following boundary.
    w_xfer = cfg.cfg_valid && !r_pend_v;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_cnt_nxt = w_last ? '0 : r_cnt + ONE;
        if (!en) w_state_nxt = ST_STOPPING;
      end
      ST_STOPPING: begin
        w_cnt_nxt = w_last ? '0 : r_cnt + ONE;
        if (en)          w_state_nxt = ST_RUN;
        else if (w_last) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (r_pend_v && (r_state == ST_IDLE || w_last)) begin
      w_div_nxt    = r_pend;
      w_pend_v_nxt = 1'b0;
    end

    if (w_xfer) begin
      if (cfg.cfg_div < TWO) begin
        w_cfg_err_nxt = 1'b1;
      end else begin
        w_pend_nxt   = cfg.cfg_div;
        w_pend_v_nxt = 1'b1;
      end
    end

    // Outputs are registered from the next-cycle count/divisor so that in the
    // cycle holding cnt=k, clk_out already equals (k < hi).
    w_active_nxt = (w_state_nxt != ST_IDLE);
    w_hi_nxt     = ({1'b0, w_div_nxt} + (W+1)'(1)) >> 1;
    w_clk_nxt    = w_active_nxt && ({1'b0, w_cnt_nxt} < w_hi_nxt);
    w_tick_nxt   = w_active_nxt && (w_cnt_nxt == w_div_nxt - ONE);
  end

  assign clk_out       = r_clk_out;
  assign tick          = r_tick;
  assign div_cur       = r_div_q;
  assign running       = (r_state != ST_IDLE);
  assign cfg.cfg_ready = !r_pend_v;
  assign cfg.cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_divm_sched.sv
module tb_divm_sched;
  localparam int W           = 8;
  localparam int DIV_DEFAULT = 4;

  logic         clk_in  = 1'b0;
  logic         reset_L = 1'b0;
  logic         en      = 1'b0;
  logic         clk_out;
  logic         tick;
  logic         running;
  logic [W-1:0] div_cur;

  divm_sched_if #(.W(W)) cfg_if ();

  divm_sched #(.W(W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
    .clk_in  (clk_in),
    .reset_L (reset_L),
    .en      (en),
    .cfg     (cfg_if.slave),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur),
    .running (running)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: output-period view. mode 0=idle 1=run 2=stopping,
  // k = position inside the current output period, M = divisor in effect.
  int m_mode, m_k, m_M, m_pend, m_pv, m_err;

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_M = DIV_DEFAULT; m_pend = 0; m_pv = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit period_end, apply, xfer;
    int d;
    d          = int'(cfg_if.cfg_div);
    period_end = (m_mode != 0) && (m_k == m_M - 1);
    apply      = (m_pv != 0) && (m_mode == 0 || period_end);
    xfer       = cfg_if.cfg_valid && (m_pv == 0);
    if (m_mode == 0 || period_end) m_k = 0;
    else m_k = m_k + 1;
    if (en) m_mode = 1;
    else if (m_mode == 1) m_mode = 2;
    else if (m_mode == 2 && period_end) m_mode = 0;
    if (apply) begin m_M = m_pend; m_pv = 0; end
    m_err = (xfer && d < 2) ? 1 : 0;
    if (xfer && d >= 2) begin m_pend = d; m_pv = 1; end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    en = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div = '0;
    repeat (2) @(negedge clk_in);
    model_reset();
    reset_L = 1'b1;
  endtask

  // Leaves the bench observing the first RUN cycle (cnt=0) with the default divisor.
  task automatic start_run();
    do_reset();
    en = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp += 6;
    if (clk_out !== 1'b0) begin n_err++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
    if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", tick); end
    if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_if.cfg_err); end
    if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_if.cfg_ready); end
    if (running !== 1'b0) begin n_err++; $display("FAIL reset_running got=%b exp=0", running); end
    if (div_cur !== W'(DIV_DEFAULT)) begin n_err++; $display("FAIL reset_div_cur got=%0d exp=%0d", div_cur, DIV_DEFAULT); end
  endtask

  task automatic test_run_m4();
    start_run();
    for (int i = 0; i < 12; i++) begin
      n_cmp += 3;
      if (clk_out !== ((i % 4) < 2)) begin n_err++; $display("FAIL m4_clk i=%0d got=%b exp=%b", i, clk_out, (i % 4) < 2); end
      if (tick !== ((i % 4) == 3)) begin n_err++; $display("FAIL m4_tick i=%0d got=%b exp=%b", i, tick, (i % 4) == 3); end
      if (running !== 1'b1) begin n_err++; $display("FAIL m4_running i=%0d got=%b exp=1", i, running); end
      cycle();
    end
  endtask

  task automatic test_div_up();
    logic e_clk [10] = '{1,1,0,0,1,1,1,0,0,0};
    logic e_rdy [10] = '{1,1,0,0,1,1,1,1,1,1};
    int   e_div [10] = '{4,4,4,4,6,6,6,6,6,6};
    start_run();
    for (int i = 0; i < 10; i++) begin
      cfg_if.cfg_valid = (i == 1);
      cfg_if.cfg_div = 8'd6;
      n_cmp += 4;
      if (clk_out !== e_clk[i]) begin n_err++; $display("FAIL up_clk i=%0d got=%b exp=%b", i, clk_out, e_clk[i]); end
      if (cfg_if.cfg_ready !== e_rdy[i]) begin n_err++; $display("FAIL up_ready i=%0d got=%b exp=%b", i, cfg_if.cfg_ready, e_rdy[i]); end
      if (div_cur !== W'(e_div[i])) begin n_err++; $display("FAIL up_div i=%0d got=%0d exp=%0d", i, div_cur, e_div[i]); end
      if (tick !== (i == 3 || i == 9)) begin n_err++; $display("FAIL up_tick i=%0d got=%b exp=%b", i, tick, (i == 3 || i == 9)); end
      cycle();
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_div_boundary();
    logic e_clk [14] = '{1,1,0,0,1,1,0,0,1,1,0,1,1,0};
    logic e_rdy [14] = '{1,1,1,1,0,0,0,0,1,1,1,1,1,1};
    int   e_div [14] = '{4,4,4,4,4,4,4,4,3,3,3,3,3,3};
    start_run();
    for (int i = 0; i < 14; i++) begin
      cfg_if.cfg_valid = (i == 3);
      cfg_if.cfg_div = 8'd3;
      n_cmp += 4;
      if (clk_out !== e_clk[i]) begin n_err++; $display("FAIL bnd_clk i=%0d got=%b exp=%b", i, clk_out, e_clk[i]); end
      if (cfg_if.cfg_ready !== e_rdy[i]) begin n_err++; $display("FAIL bnd_ready i=%0d got=%b exp=%b", i, cfg_if.cfg_ready, e_rdy[i]); end
      if (div_cur !== W'(e_div[i])) begin n_err++; $display("FAIL bnd_div i=%0d got=%0d exp=%0d", i, div_cur, e_div[i]); end
      if (tick !== (i == 3 || i == 7 || i == 10 || i == 13)) begin n_err++; $display("FAIL bnd_tick i=%0d got=%b", i, tick); end
      cycle();
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_bad_div();
    start_run();
    for (int i = 0; i < 12; i++) begin
      cfg_if.cfg_valid = (i == 1 || i == 5);
      cfg_if.cfg_div = (i == 1) ? 8'd1 : 8'd0;
      n_cmp += 4;
      if (cfg_if.cfg_err !== (i == 2 || i == 6)) begin n_err++; $display("FAIL bad_err i=%0d got=%b exp=%b", i, cfg_if.cfg_err, (i == 2 || i == 6)); end
      if (div_cur !== W'(DIV_DEFAULT)) begin n_err++; $display("FAIL bad_div i=%0d got=%0d exp=%0d", i, div_cur, DIV_DEFAULT); end
      if (clk_out !== ((i % 4) < 2)) begin n_err++; $display("FAIL bad_clk i=%0d got=%b exp=%b", i, clk_out, (i % 4) < 2); end
      if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL bad_ready i=%0d got=%b exp=1", i, cfg_if.cfg_ready); end
      cycle();
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_stop();
    logic e_clk [10] = '{1,1,1,0,0,0,0,0,0,0};
    logic e_run [10] = '{1,1,1,1,1,0,0,0,0,0};
    do_reset();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div = 8'd5;
    cycle();
    cfg_if.cfg_valid = 1'b0;
    n_cmp += 2;
    if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready got=%b exp=0", cfg_if.cfg_ready); end
    if (running !== 1'b0) begin n_err++; $display("FAIL idle_running got=%b exp=0", running); end
    cycle();
    n_cmp += 2;
    if (div_cur !== 8'd5) begin n_err++; $display("FAIL idle_apply got=%0d exp=5", div_cur); end
    if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready2 got=%b exp=1", cfg_if.cfg_ready); end
    en = 1'b1;
    cycle();
    for (int i = 0; i < 10; i++) begin
      if (i == 1) en = 1'b0;
      n_cmp += 3;
      if (clk_out !== e_clk[i]) begin n_err++; $display("FAIL stop_clk i=%0d got=%b exp=%b", i, clk_out, e_clk[i]); end
      if (running !== e_run[i]) begin n_err++; $display("FAIL stop_running i=%0d got=%b exp=%b", i, running, e_run[i]); end
      if (tick !== (i == 4)) begin n_err++; $display("FAIL stop_tick i=%0d got=%b exp=%b", i, tick, (i == 4)); end
      cycle();
    end
    en = 1'b1;
    cycle();
    for (int i = 0; i < 15; i++) begin
      en = (i != 1);
      n_cmp += 3;
      if (clk_out !== ((i % 5) < 3)) begin n_err++; $display("FAIL reen_clk i=%0d got=%b exp=%b", i, clk_out, (i % 5) < 3); end
      if (running !== 1'b1) begin n_err++; $display("FAIL reen_running i=%0d got=%b exp=1", i, running); end
      if (tick !== ((i % 5) == 4)) begin n_err++; $display("FAIL reen_tick i=%0d got=%b exp=%b", i, tick, (i % 5) == 4); end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    start_run();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div = 8'd7;
    cycle();
    cfg_if.cfg_valid = 1'b0;
    n_cmp += 2;
    if (cfg_if.cfg_ready !== 1'b0) begin n_err++; $display("FAIL mid_pend_ready got=%b exp=0", cfg_if.cfg_ready); end
    if (clk_out !== 1'b1) begin n_err++; $display("FAIL mid_pre_clk got=%b exp=1", clk_out); end
    #2;
    reset_L = 1'b0;
    #1;
    n_cmp += 5;
    if (clk_out !== 1'b0) begin n_err++; $display("FAIL mid_clk got=%b exp=0", clk_out); end
    if (running !== 1'b0) begin n_err++; $display("FAIL mid_running got=%b exp=0", running); end
    if (cfg_if.cfg_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got=%b exp=1", cfg_if.cfg_ready); end
    if (div_cur !== W'(DIV_DEFAULT)) begin n_err++; $display("FAIL mid_div got=%0d exp=%0d", div_cur, DIV_DEFAULT); end
    if (tick !== 1'b0) begin n_err++; $display("FAIL mid_tick got=%b exp=0", tick); end
    @(negedge clk_in);
    model_reset();
    reset_L = 1'b1;
    cycle();
    for (int i = 0; i < 12; i++) begin
      n_cmp += 2;
      if (clk_out !== ((i % 4) < 2)) begin n_err++; $display("FAIL post_clk i=%0d got=%b exp=%b", i, clk_out, (i % 4) < 2); end
      if (div_cur !== W'(DIV_DEFAULT)) begin n_err++; $display("FAIL post_div i=%0d got=%0d exp=%0d", i, div_cur, DIV_DEFAULT); end
      cycle();
    end
  endtask

  task automatic test_random();
    logic e_clk, e_tick, e_run, e_rdy, e_err;
    int r;
    do_reset();
    en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 15));
      if (r == 0) cfg_if.cfg_div = 8'd0;
      else if (r == 1) cfg_if.cfg_div = 8'd1;
      else if (r == 2) cfg_if.cfg_div = W'($urandom_range(10, 30));
      else cfg_if.cfg_div = W'($urandom_range(2, 8));
      cycle();
      e_run  = (m_mode != 0);
      e_clk  = e_run && (m_k < (m_M + 1) / 2);
      e_tick = e_run && (m_k == m_M - 1);
      e_rdy  = (m_pv == 0);
      e_err  = (m_err != 0);
      n_cmp += 6;
      if (clk_out !== e_clk) begin n_err++; $display("FAIL rnd_clk n=%0d got=%b exp=%b", n, clk_out, e_clk); end
      if (tick !== e_tick) begin n_err++; $display("FAIL rnd_tick n=%0d got=%b exp=%b", n, tick, e_tick); end
      if (running !== e_run) begin n_err++; $display("FAIL rnd_running n=%0d got=%b exp=%b", n, running, e_run); end
      if (cfg_if.cfg_ready !== e_rdy) begin n_err++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, cfg_if.cfg_ready, e_rdy); end
      if (cfg_if.cfg_err !== e_err) begin n_err++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, cfg_if.cfg_err, e_err); end
      if (div_cur !== W'(m_M)) begin n_err++; $display("FAIL rnd_div n=%0d got=%0d exp=%0d", n, div_cur, m_M); end
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div = '0;
    model_reset();
    test_reset();
    test_run_m4();
    test_div_up();
    test_div_boundary();
    test_bad_div();
    test_stop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
